axi4_mem_arbiter: RTL and testbench

- Two-master, one-slave AXI4 arbiter in front of the physical-memory slave (pmem).
- Master 0 is the instruction fetch unit and is read-only (AR/R). Master 1 is the load/store unit (AR/R/AW/W/B).
- The slave serves exactly one transaction at a time. The arbiter grants one master, forwards that master's channels, and holds the grant until the transaction completes.

---
 rtl/axi4_mem_arbiter_pkg.sv | 18 +
 rtl/axi4_mem_arbiter_arb_rr2.sv | 32 +++
 rtl/axi4_mem_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_axi4_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_mem_arbiter_pkg.sv
// rtl/axi4_mem_arbiter_pkg.sv - shared state encoding, AXI response codes and width defaults for axi4_mem_arbiter
package axi4_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RD_M0 = 2'b01,
        RD_M1 = 2'b10,
        WR_M1 = 2'b11
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;
    localparam int ID_W_DEF   = 4;

endpackage

// File: rtl/axi4_mem_arbiter_arb_rr2.sv
// rtl/axi4_mem_arbiter_arb_rr2.sv - two-requester round-robin picker with its pointer register
module arb_rr2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // ptr names the requester granted least recently; it wins a tie
    logic ptr;

    // one-hot grant: a lone requester always wins, a tie goes to ptr
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // pointer moves to the other requester whenever a grant is taken
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/axi4_mem_arbiter.sv
// rtl/axi4_mem_arbiter.sv - two-master (IFU read-only, LSU read/write) to one pmem slave AXI4 arbiter; ARB_FIXED_PRIO_EN selects fixed LSU priority
module axi4_mem_arbiter
    import axi4_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    // master 0 (IFU) read
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [1:0]          m0_rresp,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rlast,
    output logic [ID_W-1:0]     m0_rid,
    // master 1 (LSU) read
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [1:0]          m1_rresp,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rlast,
    output logic [ID_W-1:0]     m1_rid,
    // master 1 (LSU) write
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,
    output logic [ID_W-1:0]     m1_bid,
    // slave side toward pmem
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [ID_W-1:0]     s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [1:0]          s_rresp,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rlast,
    input  logic [ID_W-1:0]     s_rid,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [ID_W-1:0]     s_awid,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp,
    input  logic [ID_W-1:0]     s_bid
);

    arb_state_t state;
    arb_state_t state_next;
    logic       ar_done;
    logic       aw_done;
    logic       w_done;
    logic       m1_rd_req;
    logic [1:0] req;
    logic [1:0] gnt;

    // LSU read outranks LSU write; a write only counts once AW and W are both offered
    assign m1_rd_req = m1_arvalid;
    assign req       = {m1_arvalid | (m1_awvalid & m1_wvalid), m0_arvalid};

`ifdef ARB_FIXED_PRIO_EN
    assign gnt = {req[1], req[0] & ~req[1]};
`else
    logic rr_advance;
    assign rr_advance = (state == IDLE);

    arb_rr2 u_arb_rr2 (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (rr_advance),
        .gnt     (gnt)
    );
`endif

    // grant state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // per-grant handshake-done flags so each address/data beat is offered to pmem only once
    always_ff @(posedge clock) begin
        if (reset || (state == IDLE)) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (s_arvalid && s_arready) ar_done <= 1'b1;
            if (s_awvalid && s_awready) aw_done <= 1'b1;
            if (s_wvalid && s_wready)   w_done  <= 1'b1;
        end
    end

    // next-state and channel routing; everything idles at zero unless the state grants it
    always_comb begin
        state_next = state;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arid     = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_awid     = '0;
        s_awlen    = '0;
        s_awsize   = '0;
        s_awburst  = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wlast    = 1'b0;
        s_bready   = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rresp   = RESP_OKAY;
        m0_rdata   = '0;
        m0_rlast   = 1'b0;
        m0_rid     = '0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rresp   = RESP_OKAY;
        m1_rdata   = '0;
        m1_rlast   = 1'b0;
        m1_rid     = '0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = RESP_OKAY;
        m1_bid     = '0;
        case (state)
            IDLE: begin
                if (gnt[1]) begin
                    state_next = m1_rd_req ? RD_M1 : WR_M1;
                end else if (gnt[0]) begin
                    state_next = RD_M0;
                end
            end
            RD_M0: begin
                s_arvalid  = m0_arvalid && !ar_done;
                s_araddr   = m0_araddr;
                s_arid     = m0_arid;
                s_arlen    = m0_arlen;
                s_arsize   = m0_arsize;
                s_arburst  = m0_arburst;
                m0_arready = s_arready && !ar_done;
                m0_rvalid  = s_rvalid;
                m0_rresp   = s_rresp;
                m0_rdata   = s_rdata;
                m0_rlast   = s_rlast;
                m0_rid     = s_rid;
                s_rready   = m0_rready;
                if (s_rvalid && m0_rready && s_rlast) state_next = IDLE;
            end
            RD_M1: begin
                s_arvalid  = m1_arvalid && !ar_done;
                s_araddr   = m1_araddr;
                s_arid     = m1_arid;
                s_arlen    = m1_arlen;
                s_arsize   = m1_arsize;
                s_arburst  = m1_arburst;
                m1_arready = s_arready && !ar_done;
                m1_rvalid  = s_rvalid;
                m1_rresp   = s_rresp;
                m1_rdata   = s_rdata;
                m1_rlast   = s_rlast;
                m1_rid     = s_rid;
                s_rready   = m1_rready;
                if (s_rvalid && m1_rready && s_rlast) state_next = IDLE;
            end
            WR_M1: begin
                s_awvalid  = m1_awvalid && !aw_done;
                s_awaddr   = m1_awaddr;
                s_awid     = m1_awid;
                s_awlen    = m1_awlen;
                s_awsize   = m1_awsize;
                s_awburst  = m1_awburst;
                m1_awready = s_awready && !aw_done;
                s_wvalid   = m1_wvalid && !w_done;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wlast    = m1_wlast;
                m1_wready  = s_wready && !w_done;
                m1_bvalid  = s_bvalid;
                m1_bresp   = s_bresp;
                m1_bid     = s_bid;
                s_bready   = m1_bready;
                if (s_bvalid && m1_bready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// tb/tb_axi4_mem_arbiter.sv - directed self-checking bench for axi4_mem_arbiter (honours ARB_FIXED_PRIO_EN)
module tb_axi4_mem_arbiter;
    import axi4_mem_arbiter_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [31:0] m0_araddr;
    logic [3:0]  m0_arid, m0_rid;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic [63:0] m0_rdata;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [31:0] m1_araddr;
    logic [3:0]  m1_arid, m1_rid;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic [63:0] m1_rdata;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr;
    logic [3:0]  m1_awid, m1_bid;
    logic [7:0]  m1_awlen;
    logic [2:0]  m1_awsize;
    logic [1:0]  m1_awburst, m1_bresp;
    logic [63:0] m1_wdata;
    logic [7:0]  m1_wstrb;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic [63:0] s_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awid, s_bid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_0040;

    axi4_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
        .m0_rlast(m0_rlast), .m0_rid(m0_rid),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata),
        .m1_rlast(m1_rlast), .m1_rid(m1_rid),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .m1_bid(m1_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_bid(s_bid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    // called on the first cycle of a read grant; finishes in the IDLE cycle after the last beat
    task automatic serve_read(input int m, input int beats, input logic [31:0] addr,
                              input logic [63:0] d0, input logic [3:0] id);
        #1;
        chk("rd_state", 64'(dut.state), (m != 0) ? 64'(RD_M1) : 64'(RD_M0));
        chk("rd_arready_granted", 64'((m != 0) ? m1_arready : m0_arready), 64'd1);
        chk("rd_arready_other", 64'((m != 0) ? m0_arready : m1_arready), 64'd0);
        chk("rd_araddr", 64'(s_araddr), 64'(addr));
        chk("rd_arlen", 64'(s_arlen), 64'(beats - 1));
        tick;
        #1;
        chk("rd_ar_once", 64'(s_arvalid), 64'd0);
        if (m != 0) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        for (int b = 0; b < beats; b++) begin
            s_rvalid = 1'b1;
            s_rdata  = d0 + 64'(b);
            s_rlast  = (b == beats - 1);
            s_rid    = id;
            #1;
            chk("rd_rvalid_granted", 64'((m != 0) ? m1_rvalid : m0_rvalid), 64'd1);
            chk("rd_rvalid_other", 64'((m != 0) ? m0_rvalid : m1_rvalid), 64'd0);
            chk("rd_rdata", (m != 0) ? m1_rdata : m0_rdata, d0 + 64'(b));
            chk("rd_rlast", 64'((m != 0) ? m1_rlast : m0_rlast), 64'(b == beats - 1));
            chk("rd_rid", 64'((m != 0) ? m1_rid : m0_rid), 64'(id));
            tick;
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("rd_back_to_idle", 64'(dut.state), 64'(IDLE));
    endtask

    int order [3];

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        order = '{1, 1, 1};
`else
        order = '{0, 1, 0};
`endif
        reset = 1'b1;
        m0_arvalid = 1'b1; m0_araddr = A0; m0_arid = 4'h1; m0_arlen = 8'd0; m0_arsize = 3'd3;
        m0_arburst = 2'b01; m0_rready = 1'b1;
        m1_arvalid = 1'b0; m1_araddr = A1; m1_arid = 4'h6; m1_arlen = 8'd0; m1_arsize = 3'd3;
        m1_arburst = 2'b01; m1_rready = 1'b1;
        m1_awvalid = 1'b0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd3;
        m1_awburst = 2'b01; m1_wvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b0;
        m1_bready = 1'b1;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rresp = RESP_OKAY; s_rdata = 64'hFFFF; s_rlast = 1'b1;
        s_rid = '0; s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = RESP_OKAY; s_bid = '0;

        // reset: nothing forwarded even with requests and responses presented
        tick;
        tick;
        #1;
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        chk("rst_m0_arready", 64'(m0_arready), 64'd0);
        chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        chk("rst_s_araddr", 64'(s_araddr), 64'd0);
        chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        chk("rst_s_rready", 64'(s_rready), 64'd0);
        reset = 1'b0;
        s_rvalid = 1'b0;
        s_rlast = 1'b0;

        // simultaneous reads from both masters, both kept requesting for three grants
        m1_arvalid = 1'b1;
        #1;
        chk("idle_no_arready0", 64'(m0_arready), 64'd0);
        chk("idle_no_arready1", 64'(m1_arready), 64'd0);
        chk("idle_no_s_arvalid", 64'(s_arvalid), 64'd0);
        for (int r = 0; r < 3; r++) begin
            tick;
            serve_read(order[r], 1, (order[r] != 0) ? A1 : A0, 64'h100 * 64'(r + 1),
                       (order[r] != 0) ? 4'h6 : 4'h1);
            m0_arvalid = 1'b1;
            m1_arvalid = 1'b1;
        end
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        tick;
        #1;
        chk("collide_drain_idle", 64'(dut.state), 64'(IDLE));

        // lone IFU single-beat read
        m0_arvalid = 1'b1;
        tick;
        serve_read(0, 1, A0, 64'h1122_3344_5566_7788, 4'h2);

        // LSU single-beat write; IFU request raised during it must stall until B completes
        m1_awvalid = 1'b1; m1_awaddr = 32'h8000_0100; m1_awid = 4'h5; m1_awlen = 8'd0;
        m1_wvalid = 1'b1; m1_wdata = 64'hDEAD_BEEF; m1_wstrb = 8'h0F; m1_wlast = 1'b1;
        tick;
        #1;
        chk("wr_state", 64'(dut.state), 64'(WR_M1));
        chk("wr_s_awvalid", 64'(s_awvalid), 64'd1);
        chk("wr_s_awaddr", 64'(s_awaddr), 64'h8000_0100);
        chk("wr_s_wvalid", 64'(s_wvalid), 64'd1);
        chk("wr_s_wdata", s_wdata, 64'hDEAD_BEEF);
        chk("wr_s_wstrb", 64'(s_wstrb), 64'h0F);
        chk("wr_awready", 64'(m1_awready), 64'd1);
        m0_arvalid = 1'b1;
        #1;
        chk("wr_m0_blocked", 64'(m0_arready), 64'd0);
        tick;
        #1;
        chk("wr_aw_once", 64'(s_awvalid), 64'd0);
        chk("wr_w_once", 64'(s_wvalid), 64'd0);
        m1_awvalid = 1'b0;
        m1_wvalid = 1'b0;
        s_bvalid = 1'b1; s_bresp = RESP_OKAY; s_bid = 4'h5;
        #1;
        chk("wr_bvalid", 64'(m1_bvalid), 64'd1);
        chk("wr_bresp", 64'(m1_bresp), 64'd0);
        chk("wr_bid", 64'(m1_bid), 64'h5);
        chk("wr_m0_blocked_b", 64'(m0_arready), 64'd0);
        tick;
        s_bvalid = 1'b0;
        #1;
        chk("wr_idle", 64'(dut.state), 64'(IDLE));
        chk("wr_idle_m0_blocked", 64'(m0_arready), 64'd0);
        tick;
        serve_read(0, 1, A0, 64'h77, 4'h1);

        // IFU burst of 4; LSU read waits and is granted two cycles after the last beat
        m0_arlen = 8'd3;
        m0_arvalid = 1'b1;
        tick;
        m1_arvalid = 1'b1;
        serve_read(0, 4, A0, 64'hA000, 4'h3);
        tick;
        serve_read(1, 1, A1, 64'hB000, 4'h6);

        // reset mid-burst during an LSU read abandons it; an IFU read afterwards completes
        m1_arlen = 8'd3;
        m1_arvalid = 1'b1;
        tick;
        tick;
        m1_arvalid = 1'b0;
        s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 64'hC0DE; s_rresp = RESP_SLVERR; s_rid = 4'h6;
        #1;
        chk("rst_mid_rvalid", 64'(m1_rvalid), 64'd1);
        chk("rst_mid_rresp", 64'(m1_rresp), 64'(RESP_SLVERR));
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_mid_state", 64'(dut.state), 64'(IDLE));
        chk("rst_mid_m1_rvalid", 64'(m1_rvalid), 64'd0);
        chk("rst_mid_s_rready", 64'(s_rready), 64'd0);
        chk("rst_mid_s_arvalid", 64'(s_arvalid), 64'd0);
        s_rvalid = 1'b0;
        s_rresp = RESP_OKAY;
        m0_arlen = 8'd0;
        m0_arvalid = 1'b1;
        tick;
        serve_read(0, 1, A0, 64'h5A5A, 4'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
